// File: rtl/udma_lin_ch_alloc_pkg.sv
// Shared types for the uDMA linear channel allocator.
// Widths depend on module parameters, so the ownership entry struct lives in the top module.
package udma_lin_ch_alloc_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/udma_ch_free_fifo.sv
// Circular FIFO holding free channel IDs; pointers wrap modulo DEPTH.
// Overflow/underflow cannot happen in the allocator and are asserted.
module udma_ch_free_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && !pop_i && (count_q == CNT_FULL)));
      assert (!(pop_i && (count_q == '0)));
    end
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/udma_lin_ch_alloc.sv
// Runtime allocator for uDMA linear channel IDs: free list plus ownership table.
// Optional macro UDMA_LIN_CH_ALLOC_BYPASS_EN hands a freed channel straight to an alloc on an empty list.
module udma_lin_ch_alloc
  import udma_lin_ch_alloc_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int N_PERIPHS = 7,
  localparam int CH_ID_W  = $clog2(N_CH),
  localparam int PER_ID_W = $clog2(N_PERIPHS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_valid_i,
  input  logic [PER_ID_W-1:0] alloc_per_id_i,
  output logic                alloc_ready_o,
  output logic                alloc_rsp_valid_o,
  output logic [CH_ID_W-1:0]  alloc_rsp_ch_id_o,
  output logic                alloc_rsp_err_o,
  input  logic                free_valid_i,
  input  logic [CH_ID_W-1:0]  free_ch_id_i,
  input  logic [PER_ID_W-1:0] free_per_id_i,
  output logic                free_ready_o,
  output logic                free_rsp_valid_o,
  output logic                free_rsp_err_o,
  input  logic                flush_valid_i,
  input  logic [PER_ID_W-1:0] flush_per_id_i,
  output logic                flush_done_o,
  input  logic [CH_ID_W-1:0]  lookup_ch_id_i,
  output logic                lookup_alloc_o,
  output logic [PER_ID_W-1:0] lookup_per_id_o,
  output logic [CH_ID_W:0]    n_free_o,
  output logic                init_done_o
);

  localparam logic [CH_ID_W-1:0] LAST_IDX = CH_ID_W'(N_CH - 1);

  typedef struct packed {
    logic                alloc;
    logic [PER_ID_W-1:0] per_id;
  } own_entry_t;

  own_entry_t          own_tbl [N_CH];
  alloc_state_e        state_q, state_d;
  logic [CH_ID_W-1:0]  idx_q;
  logic [PER_ID_W-1:0] flush_per_q;
  logic                init_done_q;

  logic                fifo_push, fifo_pop, fifo_empty;
  logic [CH_ID_W-1:0]  fifo_wdata, fifo_head;
  logic [CH_ID_W:0]    fifo_count;

  logic                alloc_fire, free_fire, free_in_range, free_ok;
  logic                alloc_ok, bypass, sweep_hit, idx_last;
  logic [CH_ID_W-1:0]  grant_ch;

  logic                alloc_rsp_vld_p1, alloc_rsp_err_p1;
  logic [CH_ID_W-1:0]  alloc_rsp_ch_p1;
  logic                free_rsp_vld_p1, free_rsp_err_p1;
  logic                flush_done_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // ready drops combinationally while a flush is requested so flush wins the cycle
  always_comb begin
    state_d       = state_q;
    alloc_ready_o = 1'b0;
    free_ready_o  = 1'b0;
    case (state_q)
      ST_INIT:  if (idx_last) state_d = ST_IDLE;
      ST_IDLE: begin
        if (flush_valid_i) begin
          state_d = ST_FLUSH;
        end else begin
          alloc_ready_o = 1'b1;
          free_ready_o  = 1'b1;
        end
      end
      ST_FLUSH: if (idx_last) state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  assign idx_last      = (idx_q == LAST_IDX);
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  assign free_fire     = free_valid_i & free_ready_o;
  assign free_in_range = ({1'b0, free_ch_id_i} < (CH_ID_W + 1)'(N_CH));
  assign free_ok       = free_fire & free_in_range & own_tbl[free_ch_id_i].alloc
                         & (own_tbl[free_ch_id_i].per_id == free_per_id_i);
  assign sweep_hit     = (state_q == ST_FLUSH) & own_tbl[idx_q].alloc
                         & (own_tbl[idx_q].per_id == flush_per_q);

`ifdef UDMA_LIN_CH_ALLOC_BYPASS_EN
  assign bypass = alloc_fire & fifo_empty & free_ok;
`else
  assign bypass = 1'b0;
`endif

  assign alloc_ok = alloc_fire & (~fifo_empty | bypass);
  assign grant_ch = bypass ? free_ch_id_i : fifo_head;
  assign fifo_pop = alloc_fire & ~fifo_empty;

  // INIT, flush sweep and free never push in the same cycle (state-exclusive)
  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = idx_q;
    if (state_q == ST_INIT) begin
      fifo_push = 1'b1;
    end else if (sweep_hit) begin
      fifo_push = 1'b1;
    end else if (free_ok && !bypass) begin
      fifo_push  = 1'b1;
      fifo_wdata = free_ch_id_i;
    end
  end

  udma_ch_free_fifo #(
    .DEPTH (N_CH),
    .WIDTH (CH_ID_W),
    .CNT_W (CH_ID_W + 1)
  ) u_free_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  // alloc write comes last so a bypassed channel ends up owned by the requester
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) own_tbl[i] <= '0;
    end else begin
      if (free_ok)   own_tbl[free_ch_id_i] <= '0;
      if (sweep_hit) own_tbl[idx_q] <= '0;
      if (alloc_ok)  own_tbl[grant_ch] <= '{alloc: 1'b1, per_id: alloc_per_id_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      flush_per_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT || state_q == ST_FLUSH)
        idx_q <= idx_last ? '0 : idx_q + CH_ID_W'(1);
      if (state_q == ST_IDLE && flush_valid_i)
        flush_per_q <= flush_per_id_i;
      if (state_q == ST_INIT && idx_last)
        init_done_q <= 1'b1;
    end
  end

  // response stage p1: registered one cycle after the handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_rsp_vld_p1 <= 1'b0;
      alloc_rsp_err_p1 <= 1'b0;
      alloc_rsp_ch_p1  <= '0;
      free_rsp_vld_p1  <= 1'b0;
      free_rsp_err_p1  <= 1'b0;
      flush_done_p1    <= 1'b0;
    end else begin
      alloc_rsp_vld_p1 <= alloc_fire;
      alloc_rsp_err_p1 <= alloc_fire & ~alloc_ok;
      alloc_rsp_ch_p1  <= alloc_ok ? grant_ch : '0;
      free_rsp_vld_p1  <= free_fire;
      free_rsp_err_p1  <= free_fire & ~free_ok;
      flush_done_p1    <= (state_q == ST_FLUSH) & idx_last;
    end
  end

  assign alloc_rsp_valid_o = alloc_rsp_vld_p1;
  assign alloc_rsp_err_o   = alloc_rsp_err_p1;
  assign alloc_rsp_ch_id_o = alloc_rsp_ch_p1;
  assign free_rsp_valid_o  = free_rsp_vld_p1;
  assign free_rsp_err_o    = free_rsp_err_p1;
  assign flush_done_o      = flush_done_p1;
  assign init_done_o       = init_done_q;
  assign n_free_o          = fifo_count;
  assign lookup_alloc_o    = own_tbl[lookup_ch_id_i].alloc;
  assign lookup_per_id_o   = own_tbl[lookup_ch_id_i].alloc ? own_tbl[lookup_ch_id_i].per_id : '0;

endmodule

// File: tb/tb_udma_lin_ch_alloc.sv
// Directed self-checking bench for udma_lin_ch_alloc (N_CH=8, N_PERIPHS=7).
// Bypass expectations follow UDMA_LIN_CH_ALLOC_BYPASS_EN when the bench is built with it.
module tb_udma_lin_ch_alloc;

  localparam int N_CH = 8;
  localparam int N_PERIPHS = 7;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       alloc_valid_i;
  logic [2:0] alloc_per_id_i;
  logic       alloc_ready_o, alloc_rsp_valid_o, alloc_rsp_err_o;
  logic [2:0] alloc_rsp_ch_id_o;
  logic       free_valid_i;
  logic [2:0] free_ch_id_i, free_per_id_i;
  logic       free_ready_o, free_rsp_valid_o, free_rsp_err_o;
  logic       flush_valid_i;
  logic [2:0] flush_per_id_i;
  logic       flush_done_o;
  logic [2:0] lookup_ch_id_i;
  logic       lookup_alloc_o;
  logic [2:0] lookup_per_id_o;
  logic [3:0] n_free_o;
  logic       init_done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  udma_lin_ch_alloc #(.N_CH(N_CH), .N_PERIPHS(N_PERIPHS)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .alloc_valid_i     (alloc_valid_i),
    .alloc_per_id_i    (alloc_per_id_i),
    .alloc_ready_o     (alloc_ready_o),
    .alloc_rsp_valid_o (alloc_rsp_valid_o),
    .alloc_rsp_ch_id_o (alloc_rsp_ch_id_o),
    .alloc_rsp_err_o   (alloc_rsp_err_o),
    .free_valid_i      (free_valid_i),
    .free_ch_id_i      (free_ch_id_i),
    .free_per_id_i     (free_per_id_i),
    .free_ready_o      (free_ready_o),
    .free_rsp_valid_o  (free_rsp_valid_o),
    .free_rsp_err_o    (free_rsp_err_o),
    .flush_valid_i     (flush_valid_i),
    .flush_per_id_i    (flush_per_id_i),
    .flush_done_o      (flush_done_o),
    .lookup_ch_id_i    (lookup_ch_id_i),
    .lookup_alloc_o    (lookup_alloc_o),
    .lookup_per_id_o   (lookup_per_id_o),
    .n_free_o          (n_free_o),
    .init_done_o       (init_done_o)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_alloc(input logic [2:0] per, output logic [2:0] ch, output logic err, output logic vld);
    alloc_valid_i = 1'b1;
    alloc_per_id_i = per;
    step(1);
    alloc_valid_i = 1'b0;
    ch = alloc_rsp_ch_id_o;
    err = alloc_rsp_err_o;
    vld = alloc_rsp_valid_o;
  endtask

  task automatic do_free(input logic [2:0] ch, input logic [2:0] per, output logic err, output logic vld);
    free_valid_i = 1'b1;
    free_ch_id_i = ch;
    free_per_id_i = per;
    step(1);
    free_valid_i = 1'b0;
    err = free_rsp_err_o;
    vld = free_rsp_valid_o;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    step(2);
    checks++;
    if ({alloc_rsp_valid_o, alloc_rsp_err_o, free_rsp_valid_o, free_rsp_err_o,
         flush_done_o, init_done_o, alloc_ready_o, free_ready_o} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000000", {alloc_rsp_valid_o, alloc_rsp_err_o,
               free_rsp_valid_o, free_rsp_err_o, flush_done_o, init_done_o, alloc_ready_o, free_ready_o});
    end
    checks++;
    if (alloc_rsp_ch_id_o !== 3'd0 || n_free_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_vals ch=%0d n_free=%0d want 0 0", alloc_rsp_ch_id_o, n_free_o);
    end
    rst_i = 1'b0;
    step(7);
    checks++;
    if (init_done_o !== 1'b0 || n_free_o !== 4'd7 || alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL init_cycle7 init_done=%b n_free=%0d ready=%b want 0 7 0", init_done_o, n_free_o, alloc_ready_o);
    end
    step(1);
    checks++;
    if (init_done_o !== 1'b1 || n_free_o !== 4'd8 || alloc_ready_o !== 1'b1 || free_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL init_cycle8 init_done=%b n_free=%0d ready=%b%b want 1 8 11", init_done_o, n_free_o, alloc_ready_o, free_ready_o);
    end
    for (int i = 0; i < N_CH; i++) begin
      lookup_ch_id_i = 3'(i);
      #1;
      checks++;
      if (lookup_alloc_o !== 1'b0 || lookup_per_id_o !== 3'd0) begin
        errors++;
        $display("FAIL init_lookup ch%0d alloc=%b per=%0d want 0 0", i, lookup_alloc_o, lookup_per_id_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    alloc_valid_i = 1'b1;
    alloc_per_id_i = 3'd3;
    for (int i = 0; i < 9; i++) begin
      step(1);
      checks++;
      if (i < 8) begin
        if (alloc_rsp_valid_o !== 1'b1 || alloc_rsp_err_o !== 1'b0 || alloc_rsp_ch_id_o !== 3'(i)) begin
          errors++;
          $display("FAIL b2b_alloc%0d vld=%b err=%b ch=%0d want 1 0 %0d", i, alloc_rsp_valid_o, alloc_rsp_err_o, alloc_rsp_ch_id_o, i);
        end
      end else begin
        if (alloc_rsp_valid_o !== 1'b1 || alloc_rsp_err_o !== 1'b1 || alloc_rsp_ch_id_o !== 3'd0) begin
          errors++;
          $display("FAIL b2b_empty vld=%b err=%b ch=%0d want 1 1 0", alloc_rsp_valid_o, alloc_rsp_err_o, alloc_rsp_ch_id_o);
        end
      end
    end
    alloc_valid_i = 1'b0;
    step(1);
    checks++;
    if (alloc_rsp_valid_o !== 1'b0 || n_free_o !== 4'd0) begin
      errors++;
      $display("FAIL b2b_after vld=%b n_free=%0d want 0 0", alloc_rsp_valid_o, n_free_o);
    end
    lookup_ch_id_i = 3'd4;
    #1;
    checks++;
    if (lookup_alloc_o !== 1'b1 || lookup_per_id_o !== 3'd3) begin
      errors++;
      $display("FAIL b2b_lookup4 alloc=%b per=%0d want 1 3", lookup_alloc_o, lookup_per_id_o);
    end
  endtask

  task automatic test_free;
    logic err, vld;
    logic [2:0] ch;
    do_free(3'd5, 3'd3, err, vld);
    checks++;
    if (vld !== 1'b1 || err !== 1'b0 || n_free_o !== 4'd1) begin
      errors++;
      $display("FAIL free_ok vld=%b err=%b n_free=%0d want 1 0 1", vld, err, n_free_o);
    end
    do_free(3'd5, 3'd3, err, vld);
    checks++;
    if (vld !== 1'b1 || err !== 1'b1 || n_free_o !== 4'd1) begin
      errors++;
      $display("FAIL free_twice vld=%b err=%b n_free=%0d want 1 1 1", vld, err, n_free_o);
    end
    do_free(3'd2, 3'd4, err, vld);
    lookup_ch_id_i = 3'd2;
    #1;
    checks++;
    if (err !== 1'b1 || lookup_alloc_o !== 1'b1 || lookup_per_id_o !== 3'd3) begin
      errors++;
      $display("FAIL free_wrong_owner err=%b alloc=%b per=%0d want 1 1 3", err, lookup_alloc_o, lookup_per_id_o);
    end
    do_alloc(3'd3, ch, err, vld);
    checks++;
    if (vld !== 1'b1 || err !== 1'b0 || ch !== 3'd5 || n_free_o !== 4'd0) begin
      errors++;
      $display("FAIL realloc vld=%b err=%b ch=%0d n_free=%0d want 1 0 5 0", vld, err, ch, n_free_o);
    end
  endtask

  task automatic test_flush;
    logic err, vld;
    logic [2:0] ch;
    int low_cnt, done_cnt, done_at;
    do_free(3'd2, 3'd3, err, vld);
    do_alloc(3'd1, ch, err, vld);
    checks++;
    if (ch !== 3'd2 || err !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup ch=%0d err=%b want 2 0", ch, err);
    end
    for (int i = 3; i < 8; i++) do_free(3'(i), 3'd3, err, vld);
    checks++;
    if (n_free_o !== 4'd5) begin
      errors++;
      $display("FAIL flush_setup_nfree got %0d want 5", n_free_o);
    end
    flush_valid_i = 1'b1;
    flush_per_id_i = 3'd3;
    alloc_valid_i = 1'b1;
    alloc_per_id_i = 3'd6;
    #1;
    checks++;
    if (alloc_ready_o !== 1'b0 || free_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority ready=%b%b want 00", alloc_ready_o, free_ready_o);
    end
    low_cnt = 1;
    done_cnt = 0;
    done_at = -1;
    step(1);
    flush_valid_i = 1'b0;
    alloc_valid_i = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) step(1);
      if (alloc_ready_o === 1'b0) low_cnt++;
      if (flush_done_o === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end
    checks++;
    if (low_cnt != 9 || done_cnt != 1 || done_at != 9) begin
      errors++;
      $display("FAIL flush_timing low=%0d pulses=%0d at=%0d want 9 1 9", low_cnt, done_cnt, done_at);
    end
    checks++;
    if (n_free_o !== 4'd7) begin
      errors++;
      $display("FAIL flush_nfree got %0d want 7", n_free_o);
    end
    lookup_ch_id_i = 3'd2;
    #1;
    checks++;
    if (lookup_alloc_o !== 1'b1 || lookup_per_id_o !== 3'd1) begin
      errors++;
      $display("FAIL flush_keep_other alloc=%b per=%0d want 1 1", lookup_alloc_o, lookup_per_id_o);
    end
    lookup_ch_id_i = 3'd0;
    #1;
    checks++;
    if (lookup_alloc_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cleared ch0 alloc=%b want 0", lookup_alloc_o);
    end
  endtask

  task automatic test_simultaneous;
    logic err, vld;
    logic [2:0] ch;
    logic [2:0] exp_order [7] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    for (int i = 0; i < 7; i++) begin
      do_alloc(3'd3, ch, err, vld);
      checks++;
      if (ch !== exp_order[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL fifo_order%0d ch=%0d err=%b want %0d 0", i, ch, err, exp_order[i]);
      end
    end
    alloc_valid_i = 1'b1;
    alloc_per_id_i = 3'd2;
    free_valid_i = 1'b1;
    free_ch_id_i = 3'd6;
    free_per_id_i = 3'd3;
    step(1);
    alloc_valid_i = 1'b0;
    free_valid_i = 1'b0;
    lookup_ch_id_i = 3'd6;
    #1;
    checks++;
`ifdef UDMA_LIN_CH_ALLOC_BYPASS_EN
    if (alloc_rsp_err_o !== 1'b0 || alloc_rsp_ch_id_o !== 3'd6 || free_rsp_err_o !== 1'b0
        || n_free_o !== 4'd0 || lookup_alloc_o !== 1'b1 || lookup_per_id_o !== 3'd2) begin
      errors++;
      $display("FAIL sim_empty aerr=%b ch=%0d ferr=%b n_free=%0d own=%b/%0d want 0 6 0 0 1/2",
               alloc_rsp_err_o, alloc_rsp_ch_id_o, free_rsp_err_o, n_free_o, lookup_alloc_o, lookup_per_id_o);
    end
`else
    if (alloc_rsp_err_o !== 1'b1 || alloc_rsp_ch_id_o !== 3'd0 || free_rsp_err_o !== 1'b0
        || n_free_o !== 4'd1 || lookup_alloc_o !== 1'b0) begin
      errors++;
      $display("FAIL sim_empty aerr=%b ch=%0d ferr=%b n_free=%0d own=%b want 1 0 0 1 0",
               alloc_rsp_err_o, alloc_rsp_ch_id_o, free_rsp_err_o, n_free_o, lookup_alloc_o);
    end
`endif
    do_free(3'd7, 3'd3, err, vld);
    alloc_valid_i = 1'b1;
    alloc_per_id_i = 3'd5;
    free_valid_i = 1'b1;
    free_ch_id_i = 3'd0;
    free_per_id_i = 3'd3;
    step(1);
    alloc_valid_i = 1'b0;
    free_valid_i = 1'b0;
    checks++;
`ifdef UDMA_LIN_CH_ALLOC_BYPASS_EN
    if (alloc_rsp_err_o !== 1'b0 || alloc_rsp_ch_id_o !== 3'd7 || free_rsp_err_o !== 1'b0 || n_free_o !== 4'd1) begin
      errors++;
      $display("FAIL sim_both aerr=%b ch=%0d ferr=%b n_free=%0d want 0 7 0 1",
               alloc_rsp_err_o, alloc_rsp_ch_id_o, free_rsp_err_o, n_free_o);
    end
`else
    if (alloc_rsp_err_o !== 1'b0 || alloc_rsp_ch_id_o !== 3'd6 || free_rsp_err_o !== 1'b0 || n_free_o !== 4'd2) begin
      errors++;
      $display("FAIL sim_both aerr=%b ch=%0d ferr=%b n_free=%0d want 0 6 0 2",
               alloc_rsp_err_o, alloc_rsp_ch_id_o, free_rsp_err_o, n_free_o);
    end
`endif
  endtask

  task automatic test_reset_mid_flush;
    logic err, vld;
    logic [2:0] ch;
    flush_valid_i = 1'b1;
    flush_per_id_i = 3'd3;
    step(1);
    flush_valid_i = 1'b0;
    step(3);
    checks++;
    if (alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midflush_ready got %b want 0", alloc_ready_o);
    end
    rst_i = 1'b1;
    step(1);
    checks++;
    if ({alloc_rsp_valid_o, free_rsp_valid_o, flush_done_o, init_done_o, alloc_ready_o} !== 5'b0
        || n_free_o !== 4'd0) begin
      errors++;
      $display("FAIL midflush_reset flags=%b n_free=%0d want 00000 0",
               {alloc_rsp_valid_o, free_rsp_valid_o, flush_done_o, init_done_o, alloc_ready_o}, n_free_o);
    end
    rst_i = 1'b0;
    step(7);
    checks++;
    if (init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reinit_early init_done=%b want 0", init_done_o);
    end
    step(1);
    lookup_ch_id_i = 3'd2;
    #1;
    checks++;
    if (init_done_o !== 1'b1 || n_free_o !== 4'd8 || lookup_alloc_o !== 1'b0) begin
      errors++;
      $display("FAIL reinit init_done=%b n_free=%0d own2=%b want 1 8 0", init_done_o, n_free_o, lookup_alloc_o);
    end
    do_alloc(3'd6, ch, err, vld);
    checks++;
    if (ch !== 3'd0 || err !== 1'b0 || vld !== 1'b1) begin
      errors++;
      $display("FAIL reinit_alloc ch=%0d err=%b vld=%b want 0 0 1", ch, err, vld);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    alloc_valid_i = 1'b0;
    alloc_per_id_i = '0;
    free_valid_i = 1'b0;
    free_ch_id_i = '0;
    free_per_id_i = '0;
    flush_valid_i = 1'b0;
    flush_per_id_i = '0;
    lookup_ch_id_i = '0;
    test_reset();
    test_back_to_back();
    test_free();
    test_flush();
    test_simultaneous();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udma_lin_ch_alloc.md
Name: udma_lin_ch_alloc

Overview:
Runtime allocator for uDMA linear channel IDs. It replaces fixed compile-time channel-to-peripheral numbering with a free-list of channel IDs and an ownership table. Peripheral-side control logic requests channels through valid/ready handshakes and releases them the same way. The core mux reads the table to route each channel to its owning peripheral.

Parameters:
N_CH, 8, number of linear channels managed (>=2)
N_PERIPHS, 7, number of peripheral IDs (>=2)
CH_ID_W, $clog2(N_CH), channel ID width (derived, localparam)
PER_ID_W, $clog2(N_PERIPHS), peripheral ID width (derived, localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
alloc_valid_i  in  1  allocation request
alloc_per_id_i  in  PER_ID_W  requesting peripheral
alloc_ready_o  out  1  request accepted when high with valid
alloc_rsp_valid_o  out  1  one-cycle response pulse
alloc_rsp_ch_id_o  out  CH_ID_W  granted channel (0 on error)
alloc_rsp_err_o  out  1  no free channel
free_valid_i  in  1  release request
free_ch_id_i  in  CH_ID_W  channel to release
free_per_id_i  in  PER_ID_W  claimed owner
free_ready_o  out  1  release accepted
free_rsp_valid_o  out  1  one-cycle response pulse
free_rsp_err_o  out  1  channel not allocated, or owner mismatch
flush_valid_i  in  1  release all channels of one peripheral
flush_per_id_i  in  PER_ID_W  peripheral to flush
flush_done_o  out  1  one-cycle pulse at end of sweep
lookup_ch_id_i  in  CH_ID_W  table read index
lookup_alloc_o  out  1  channel allocated (combinational)
lookup_per_id_o  out  PER_ID_W  owner (combinational; 0 if unallocated)
n_free_o  out  CH_ID_W+1  free channel count
init_done_o  out  1  high once free list is populated

Behaviour:
- Reset (any state, any cycle): FSM to INIT, ownership table cleared, free list emptied, init index 0.
- Reset values: all rsp_valid/err/ch_id outputs 0, flush_done_o 0, n_free_o 0, init_done_o 0, ready outputs 0.
- FSM INIT: pushes init index 0..N_CH-1 into the free list, one per cycle. After N_CH cycles go to IDLE. init_done_o is set on entry to IDLE and stays high until reset.
- FSM IDLE: alloc_ready_o = free_ready_o = 1.
  - alloc handshake: pop the free-list head, mark owner. Response is registered on the next cycle (latency 1).
  - If the list is empty: rsp_err=1, ch_id=0, no state change.
  - free handshake: if the channel is allocated and the owner matches, clear the entry and push to the tail; otherwise rsp_err=1, no change. Response latency is 1.
  - flush_valid_i: latch flush_per_id_i, go to FLUSH. It has priority over alloc/free in the same cycle; those are not accepted because ready drops combinationally when flush_valid_i is high.
- FSM FLUSH: ready outputs 0. Sweep index 0..N_CH-1, one per cycle. A matching allocated entry is cleared and pushed to the tail. After index N_CH-1, pulse flush_done_o on the next cycle and return to IDLE. Duration is N_CH+1 cycles.
- Simultaneous alloc and free in IDLE: both are processed. The pop takes the pre-cycle head and the push goes to the tail. n_free_o is unchanged when both succeed.
- Free list is a circular FIFO of depth N_CH. Overflow is impossible by construction (asserted). Pointers wrap modulo N_CH.
- n_free_o is updated the same cycle as the list (registered); it equals the FIFO occupancy.
- Freed channels are reissued in FIFO (least-recently-freed) order.

Optional Feature:
UDMA_LIN_CH_ALLOC_BYPASS_EN
- Defined: an alloc on an empty list in the same cycle as a successful free grants the freed channel directly. No push or pop occurs; n_free_o stays 0; the alloc has no error.
- Undefined: that alloc returns err and the freed channel enters the list.

Decomposition:
- Package udma_lin_ch_alloc_pkg: FSM state enum (INIT, IDLE, FLUSH) and ownership entry struct {alloc, per_id}. Widths are derived from module parameters, so the struct is parametrised in the module.
- Sub-module udma_ch_free_fifo: circular FIFO, parameters DEPTH and WIDTH, push/pop/count, synchronous active-high reset, same clock.

Test Plan:
- Release rst_i with N_CH=8 -> init_done_o rises at cycle 8, n_free_o=8, all lookups show unallocated.
- 9 back-to-back allocs from per 3 -> ch_id 0..7 with no error, 9th has err=1, n_free_o=0, lookup ch 4 gives per 3.
- Free ch 5 by per 3 -> ok and n_free_o=1. Free ch 5 again -> err. Free ch 2 by per 4 -> err, ch 2 still owned by per 3. Next alloc -> ch 5.
- Channels 0,1 owned by per 3 and ch 2 by per 1; flush per 3 -> ready low 9 cycles, flush_done_o one pulse, n_free_o +2, ch 2 still owned by per 1.
- Full list, simultaneous alloc (per 2) and free (ch 6, per 3) -> with macro: alloc gets ch 6, n_free_o=0. Without: alloc err, n_free_o=1.
- Assert rst_i mid-FLUSH at sweep index 3 -> all outputs at reset values next cycle, INIT restarts, init_done_o after 8 cycles, n_free_o=8.
